// File: rtl/multiport_reg_file_if.sv
// multiport_reg_file_if: decode-read, writeback and issue signals of the register file
interface multiport_reg_file_if #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 1
);
  localparam int AW = $clog2(NREG);
  logic [NUM_READ*AW-1:0]    rd_addr;
  logic [NUM_READ*XLEN-1:0]  rd_data;
  logic [NUM_READ-1:0]       rd_ready;
  logic [NUM_WRITE-1:0]      wr_en;
  logic [NUM_WRITE*AW-1:0]   wr_addr;
  logic [NUM_WRITE*XLEN-1:0] wr_data;
  logic                      alloc_en;
  logic [AW-1:0]             alloc_addr;
  logic [NREG-1:0]           busy_vec;
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_ready, busy_vec
  );
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_ready, busy_vec
  );
endinterface

// File: rtl/multiport_reg_file.sv
// multiport_reg_file: x0-zero register file with busy scoreboard and optional write-to-read bypass
module multiport_reg_file #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 1,
  parameter int BYPASS    = 1
) (
  input logic clk,
  input logic rst,
  multiport_reg_file_if.slave bus
);
  localparam int AW = $clog2(NREG);
  logic [XLEN-1:0] regs [NREG];
  logic [XLEN-1:0] wr_val [NREG];
  logic [NREG-1:0] wr_hit;
  logic [NREG-1:0] busy;
  // Later ports overwrite earlier ones, so the highest index wins a collision
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NREG; r++) wr_val[r] = regs[r];
    for (int j = 0; j < NUM_WRITE; j++)
      if (bus.wr_en[j]) begin
        wr_hit[bus.wr_addr[j*AW +: AW]] = 1'b1;
        wr_val[bus.wr_addr[j*AW +: AW]] = bus.wr_data[j*XLEN +: XLEN];
      end
    wr_hit[0] = 1'b0;
    wr_val[0] = '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (wr_hit[r]) regs[r] <= wr_val[r];
        busy[r] <= (bus.alloc_en && bus.alloc_addr == AW'(r)) ? 1'b1 : wr_hit[r] ? 1'b0 : busy[r];
      end
    end
  assign bus.busy_vec = busy;
  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    assign ra  = bus.rd_addr[i*AW +: AW];
    assign hit = (BYPASS != 0) && wr_hit[ra];
    assign bus.rd_data[i*XLEN +: XLEN] = rst ? '0 : hit ? wr_val[ra] : regs[ra];
    assign bus.rd_ready[i] = rst || (hit ? !(bus.alloc_en && bus.alloc_addr == ra) : !busy[ra]);
  end
endmodule
